// File: rtl/uart_fifo_pkg.sv
// Shared constants for the UART byte FIFO: default geometry, RX error-bit
// positions and the ERR_W values that select TX or RX mode.
package uart_fifo_pkg;

  localparam int MODE_TX   = 0;
  localparam int MODE_RX   = 3;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_ERR_W = MODE_TX;

  localparam int ERR_PE    = 0;
  localparam int ERR_FE    = 1;
  localparam int ERR_BI    = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: synchronous write, asynchronous (fall-through) read.
// The error field only exists when ERR_W > 0.
module uart_fifo_ram
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERR_W = DEF_ERR_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int EW   = (ERR_W > 0) ? ERR_W : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [EW-1:0]    werr,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic [EW-1:0]    rerr
);

  logic [WIDTH-1:0] data_mem [DEPTH];

  // data array write port
  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[waddr] <= wdata;
    end
  end

  assign rdata = data_mem[raddr];

  generate
    if (ERR_W > 0) begin : g_err
      logic [EW-1:0] err_mem [DEPTH];

      // error array write port
      always_ff @(posedge clk) begin
        if (we) begin
          err_mem[waddr] <= werr;
        end
      end

      assign rerr = err_mem[raddr];
    end else begin : g_no_err
      logic unused_werr;
      assign unused_werr = ^werr;
      assign rerr        = '0;
    end
  endgenerate

endmodule

// File: rtl/uart_fifo_v2.sv
// Parametrised UART FIFO with trigger threshold, sticky overrun/underrun
// flags and a running count of stored entries that carry line errors.
module uart_fifo_v2
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ERR_W  = DEF_ERR_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int EW    = (ERR_W > 0) ? ERR_W : 1
) (
  input  logic             clk,
  input  logic             wb_rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic [EW-1:0]    err_in,
  input  logic             fifo_reset,
  input  logic             reset_status,
  input  logic [CNT_W-1:0] level,
  output logic [WIDTH-1:0] data_out,
  output logic [EW-1:0]    err_out,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             trigger,
  output logic             overrun,
  output logic             underrun,
  output logic             err_any
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [AW-1:0]    top_r, bottom_r;
  logic [CNT_W-1:0] count_r, err_cnt_r;
  logic             overrun_r, underrun_r;

  logic [CNT_W-1:0] count_nxt_s, err_cnt_nxt_s, level_eff_s;
  logic             full_s, empty_s, wr_en_s, rd_en_s;
  logic             ov_set_s, un_set_s, err_wr_s, err_rd_s;
  fifo_op_e         op_s;

  uart_fifo_ram #(.WIDTH(WIDTH), .ERR_W(ERR_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (top_r),
    .wdata (data_in),
    .werr  (err_in),
    .raddr (bottom_r),
    .rdata (data_out),
    .rerr  (err_out)
  );

  // request qualification and next-state arithmetic
  always_comb begin
    full_s        = (count_r == DEPTH_C);
    empty_s       = (count_r == '0);
    // a full FIFO still accepts a push when a pop frees the head slot
    wr_en_s       = push && (!full_s || pop);
    rd_en_s       = pop && !empty_s;
    ov_set_s      = push && full_s && !pop;
    un_set_s      = pop && empty_s;
    err_wr_s      = wr_en_s && (ERR_W > 0) && (|err_in);
    err_rd_s      = rd_en_s && (|err_out);
    op_s          = fifo_op_e'({wr_en_s, rd_en_s});
    count_nxt_s   = count_r;
    err_cnt_nxt_s = err_cnt_r;
    case (op_s)
      OP_PUSH: count_nxt_s = count_r + ONE_C;
      OP_POP:  count_nxt_s = count_r - ONE_C;
      OP_BOTH: count_nxt_s = count_r;
      OP_IDLE: count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
    if (err_wr_s && !err_rd_s) begin
      err_cnt_nxt_s = err_cnt_r + ONE_C;
    end else if (err_rd_s && !err_wr_s) begin
      err_cnt_nxt_s = err_cnt_r - ONE_C;
    end else begin
      err_cnt_nxt_s = err_cnt_r;
    end
  end

  // pointers, occupancy, error count and sticky flags
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      top_r      <= '0;
      bottom_r   <= '0;
      count_r    <= '0;
      err_cnt_r  <= '0;
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else if (fifo_reset) begin
      top_r      <= '0;
      bottom_r   <= '0;
      count_r    <= '0;
      err_cnt_r  <= '0;
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        top_r <= top_r + AW'(1);
      end
      if (rd_en_s) begin
        bottom_r <= bottom_r + AW'(1);
      end
      count_r    <= count_nxt_s;
      err_cnt_r  <= err_cnt_nxt_s;
      // a set event in the same cycle beats reset_status
      overrun_r  <= ov_set_s || (overrun_r && !reset_status);
      underrun_r <= un_set_s || (underrun_r && !reset_status);
    end
  end

  // status outputs derived from the registered counters
  always_comb begin
    if (level == '0) begin
      level_eff_s = ONE_C;
    end else begin
      level_eff_s = level;
    end
    count    = count_r;
    empty    = empty_s;
    full     = full_s;
    trigger  = (count_r >= level_eff_s);
    overrun  = overrun_r;
    underrun = underrun_r;
    err_any  = (err_cnt_r != '0);
  end

endmodule

// File: tb/tb_uart_fifo_v2.sv
// Self-checking bench for uart_fifo_v2 in RX mode (ERR_W=3, DEPTH=16),
// directed scenarios plus random traffic against a queue-based model.
module tb_uart_fifo_v2;
  import uart_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          push = 1'b0, pop = 1'b0, fifo_reset = 1'b0, reset_status = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic [2:0]    err_in = 3'b000;
  logic [CW-1:0] level = 5'd16;
  logic [7:0]    data_out;
  logic [2:0]    err_out;
  logic [CW-1:0] count;
  logic          empty, full, trigger, overrun, underrun, err_any;

  int tests = 0;
  int fails = 0;

  logic [10:0] mq[$];
  bit          m_ov = 1'b0, m_un = 1'b0;

  uart_fifo_v2 #(.WIDTH(8), .ERR_W(MODE_RX), .DEPTH(DEPTH)) dut (
    .clk(clk), .wb_rst_ni(rst_n), .push(push), .pop(pop),
    .data_in(data_in), .err_in(err_in), .fifo_reset(fifo_reset),
    .reset_status(reset_status), .level(level), .data_out(data_out),
    .err_out(err_out), .count(count), .empty(empty), .full(full),
    .trigger(trigger), .overrun(overrun), .underrun(underrun), .err_any(err_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n, lvl, nerr;
    n    = mq.size();
    lvl  = (level == 0) ? 1 : int'(level);
    nerr = 0;
    foreach (mq[i]) if (mq[i][10:8] != 3'b000) nerr++;
    chk("count",    32'(count),    32'(n));
    chk("empty",    32'(empty),    32'(n == 0));
    chk("full",     32'(full),     32'(n == DEPTH));
    chk("trigger",  32'(trigger),  32'(n >= lvl));
    chk("overrun",  32'(overrun),  32'(m_ov));
    chk("underrun", 32'(underrun), 32'(m_un));
    chk("err_any",  32'(err_any),  32'(nerr != 0));
    if (n > 0) begin
      chk("data_out", 32'(data_out), 32'(mq[0][7:0]));
      chk("err_out",  32'(err_out),  32'(mq[0][10:8]));
    end
  endtask

  task automatic model_update(input logic p, input logic q, input logic [7:0] d,
                              input logic [2:0] e, input logic fr, input logic rs);
    int n;
    bit ov_set, un_set;
    n = mq.size();
    if (fr) begin
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      ov_set = p && (n == DEPTH) && !q;
      un_set = q && (n == 0);
      if (q && n > 0) void'(mq.pop_front());
      if (p && (n < DEPTH || q)) mq.push_back({e, d});
      m_ov = ov_set || (m_ov && !rs);
      m_un = un_set || (m_un && !rs);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic [7:0] d,
                      input logic [2:0] e, input logic fr, input logic rs);
    push = p; pop = q; data_in = d; err_in = e; fifo_reset = fr; reset_status = rs;
    @(posedge clk);
    model_update(p, q, d, e, fr, rs);
    #1;
    push = 1'b0; pop = 1'b0; fifo_reset = 1'b0; reset_status = 1'b0;
    check_all();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all();

    // fill with 0x00..0x0F then drain in order
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), 3'b000, 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 32'(data_out), 32'(i));
      step(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0);
    end

    // overrun and reset_status interaction
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 3'b000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hAA, 3'b000, 1'b0, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    step(1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
    chk("ovr_clr", 32'(overrun), 32'd0);
    step(1'b1, 1'b0, 8'hAB, 3'b000, 1'b0, 1'b1);
    chk("ovr_wins", 32'(overrun), 32'd1);
    step(1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b1);

    // push+pop on a full FIFO wraps pointers without overrun
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'h55, 3'b000, 1'b0, 1'b0);
    chk("wrap_no_ovr", 32'(overrun), 32'd0);
    while (mq.size() > 0) step(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0);

    // push+pop on empty, then lone pop on empty
    step(1'b1, 1'b1, 8'h33, 3'b000, 1'b0, 1'b0);
    chk("pp_empty_data", 32'(data_out), 32'h33);
    step(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0);
    chk("lone_pop_un", 32'(underrun), 32'd1);

    // error tracking with trigger level 4, then flush
    level = 5'd4;
    step(1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h10, 3'b000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h11, 3'(1 << ERR_FE), 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h12, 3'b000, 1'b0, 1'b0);
    chk("trig_low", 32'(trigger), 32'd0);
    step(1'b1, 1'b0, 8'h13, 3'(1 << ERR_BI), 1'b0, 1'b0);
    chk("trig_high", 32'(trigger), 32'd1);
    step(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0);
    chk("err_any_one", 32'(err_any), 32'd1);
    step(1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
    level = 5'd0;
    #1 check_all();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      level = 5'($urandom_range(0, 16));
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 5),
           8'($urandom), ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom),
           1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) == 0));
    end

    // asynchronous reset mid-burst with count=7 and overrun set
    step(1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 3'b001, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0);
    chk("pre_rst_cnt", 32'(count), 32'd7);
    chk("pre_rst_ovr", 32'(overrun), 32'd1);
    rst_n = 1'b0;
    #1;
    mq.delete(); m_ov = 1'b0; m_un = 1'b0;
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h77, 3'b000, 1'b0, 1'b0);
    chk("post_rst_data", 32'(data_out), 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_fifo_v2.md
# uart_fifo_v2

Parametrised UART byte FIFO, successor to the fixed-size transmit/receive FIFOs. It is generalised in data width and depth, and optionally carries per-entry line-error bits for receive use. It adds a programmable trigger threshold, sticky overrun and underrun flags, and a running count of erroneous entries. It sits between the Wishbone register file and the TX/RX shift engines; one instance serves each direction.

## Interface
- `WIDTH`, 8: data bits per entry.
- `ERR_W`, 0: error bits stored per entry (0 = TX mode, no error storage; 3 = RX mode: parity, framing, break).
- `DEPTH`, 16: entries; power of two, 2..256.
- `CNT_W`, $clog2(DEPTH)+1: width of count/level signals (derived; not overridden).

- `clk` in 1: sole clock, rising edge.
- `wb_rst_ni` in 1: asynchronous active-low reset.
- `push` in 1: write `data_in`/`err_in` this cycle.
- `pop` in 1: retire head entry this cycle.
- `data_in` in WIDTH: write data.
- `err_in` in max(ERR_W,1): write error bits; ignored when ERR_W=0.
- `fifo_reset` in 1: synchronous flush of contents and flags.
- `reset_status` in 1: synchronous clear of sticky flags only.
- `level` in CNT_W: trigger threshold, 1..DEPTH.
- `data_out` out WIDTH: head entry data, fall-through (valid while `!empty`).
- `err_out` out max(ERR_W,1): head entry error bits; 0 when ERR_W=0.
- `count` out CNT_W: occupancy 0..DEPTH.
- `empty`, `full` out 1: count==0 / count==DEPTH.
- `trigger` out 1: count >= level (level 0 treated as 1).
- `overrun` out 1: sticky; push attempted while full.
- `underrun` out 1: sticky; pop attempted while empty.
- `err_any` out 1: err_cnt != 0.

## Operation
- Pointers `top` (write) and `bottom` (read) are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. `count` is tracked separately, CNT_W bits.
- Per-cycle action on {push,pop}, unless `fifo_reset`:
  - 10: if !full, write mem[top], top+1, count+1. If full, data dropped, overrun set.
  - 01: if !empty, bottom+1, count-1. If empty, no change, underrun set.
  - 11 with 0<count<DEPTH: write and retire; count unchanged.
  - 11 while full: pop retires head, push writes freed slot; count stays DEPTH; no overrun.
  - 11 while empty: push accepted, pop ignored, count becomes 1, underrun set.
- Error tracking (ERR_W>0): `err_cnt` (CNT_W) counts stored entries with nonzero error bits.
  - Increments on an accepted push with `|err_in`.
  - Decrements on an accepted pop with `|err_out`.
  - Both in one cycle: unchanged.
- `fifo_reset` has priority over push/pop. It zeroes top, bottom, count, err_cnt, overrun and underrun. Memory contents are not cleared.
- `reset_status` clears overrun/underrun. A set event in the same cycle wins, so the flag stays 1.
- Asynchronous reset (`wb_rst_ni`=0): all registers as for `fifo_reset`. Outputs then read count=0, empty=1, full=0, trigger=0, overrun=0, underrun=0, err_any=0. `data_out`/`err_out` are undefined while empty.

## Timing
- Write-to-visible latency 1 cycle: after a push into an empty FIFO at edge N, `data_out` is valid and empty=0 after edge N.
- Pop takes effect at the edge; the next head appears combinationally after that edge.
- count/empty/full/trigger/err_any are combinational from registered count/err_cnt, so they change 1 cycle after the causing push/pop.
- Flags are registered and assert the cycle after the offending request.
- Reset deassertion is synchronised externally; the block needs no internal synchroniser.

## Structure
- Package `uart_fifo_pkg`: default WIDTH/DEPTH/ERR_W constants, RX error-bit index constants (PE=0, FE=1, BI=2), and the ERR_W mode values TX=0 / RX=3.
- Sub-module `uart_fifo_ram`: DEPTH×(WIDTH+ERR_W) memory with one synchronous write port and one asynchronous read port. The error field is omitted when ERR_W=0.
- Control (pointers, count, err_cnt, flags) lives in `uart_fifo_v2`.

## Test plan
- Reset, then 16 pushes of 0x00..0x0F (DEPTH=16): full=1 and count=16. 16 pops return 0x00..0x0F in order, then empty=1, overrun=0, underrun=0.
- Full FIFO, push 0xAA: count stays 16, overrun=1 next cycle, head unchanged. Then `reset_status`: overrun=0. `reset_status` together with another full push: overrun stays 1.
- Full FIFO, push+pop of 0x55 for 20 cycles: count=16 throughout, no overrun. Pointers wrap and output order is preserved.
- Empty FIFO, push 0x33 + pop together: count=1, data_out=0x33, underrun=1. A lone pop on empty: underrun=1, count=0.
- RX mode (ERR_W=3), level=4: push 4 entries with err_in 0,2,0,4. trigger rises after the 4th push, err_cnt=2, err_any=1. Pop 2: err_cnt=1. `fifo_reset` mid-stream: count=0, err_any=0, flags 0.
- Assert `wb_rst_ni` low mid-burst with count=7, overrun=1: all outputs at reset values immediately, without waiting for a clock edge. Normal push resumes on the first edge after release.
